// File: rtl/fixed_point_mult_arbiter_pkg.sv
// Shared definitions for the fixed-point multiplier arbiter: FSM encoding and
// default sizing of the Q4.19 datapath and requester count.
package fixed_point_mult_arbiter_pkg;

  localparam int DEFAULT_BITSIZE = 24;
  localparam int DEFAULT_NREQ    = 4;
  localparam int INT_BITS        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_point_mult_arbiter_mul.sv
// Combinational signed fixed-point multiplier (1 sign, INT_BITS integer bits,
// remaining fraction bits); the product is floored and saturated to the format.
module fixed_point_multiply
  import fixed_point_mult_arbiter_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE
) (
  input  logic [BITSIZE-1:0] a_i,
  input  logic [BITSIZE-1:0] b_i,
  output logic [BITSIZE-1:0] p_o
);

  localparam int FRAC = BITSIZE - 1 - INT_BITS;
  localparam int PW   = 2 * BITSIZE;
  localparam logic signed [PW-1:0] MAXV = {{(BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] aExt;
  logic signed [PW-1:0] bExt;
  logic signed [PW-1:0] fullProd;
  logic signed [PW-1:0] scaled;

  // Double-width operands make the full product exact before rescaling.
  assign aExt     = {{BITSIZE{a_i[BITSIZE-1]}}, a_i};
  assign bExt     = {{BITSIZE{b_i[BITSIZE-1]}}, b_i};
  assign fullProd = aExt * bExt;
  assign scaled   = fullProd >>> FRAC;

  always_comb begin
    if (scaled > MAXV) begin
      p_o = MAXV[BITSIZE-1:0];
    end else if (scaled < MINV) begin
      p_o = MINV[BITSIZE-1:0];
    end else begin
      p_o = scaled[BITSIZE-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_mult_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one fixed-point
// multiplier; one operation in flight, result held until the consumer takes it.
module fixed_point_mult_arbiter
  import fixed_point_mult_arbiter_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int NREQ    = DEFAULT_NREQ
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*BITSIZE-1:0]   req_a,
  input  logic [NREQ*BITSIZE-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BITSIZE-1:0]        rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rrPtr_q, rrPtr_d;
  logic [BITSIZE-1:0] opA_q, opA_d;
  logic [BITSIZE-1:0] opB_q, opB_d;
  logic [IDW-1:0]     opId_q, opId_d;
  logic [BITSIZE-1:0] rspData_q, rspData_d;
  logic [IDW-1:0]     rspId_q, rspId_d;
  logic               rspValid_q, rspValid_d;

  logic               grantFound;
  logic [IDW-1:0]     grantIdx;
  logic [IDW:0]       candSum;
  logic [BITSIZE-1:0] mulP;

  fixed_point_multiply #(
    .BITSIZE(BITSIZE)
  ) u_mul (
    .a_i(opA_q),
    .b_i(opB_q),
    .p_o(mulP)
  );

  // Search upward from the pointer, wrapping past NREQ-1; first valid wins.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candSum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      candSum = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (candSum >= (IDW+1)'(NREQ)) begin
        candSum = candSum - (IDW+1)'(NREQ);
      end
      if (!grantFound && req_valid[candSum[IDW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candSum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opId_d     = opId_q;
    rspData_d  = rspData_q;
    rspId_d    = rspId_q;
    rspValid_d = rspValid_q;
    case (state_q)
      IDLE: begin
        if (grantFound) begin
          for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == IDW'(i)) begin
              opA_d = req_a[i*BITSIZE +: BITSIZE];
              opB_d = req_b[i*BITSIZE +: BITSIZE];
            end
          end
          opId_d  = grantIdx;
          rrPtr_d = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + IDW'(1);
          state_d = MUL;
        end
      end
      MUL: begin
        rspData_d  = mulP;
        rspId_d    = opId_q;
        rspValid_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      opId_q     <= '0;
      rspData_q  <= '0;
      rspId_q    <= '0;
      rspValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opId_q     <= opId_d;
      rspData_q  <= rspData_d;
      rspId_q    <= rspId_d;
      rspValid_q <= rspValid_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_id    = rspId_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_point_mult_arbiter.sv
// Scoreboard bench for fixed_point_mult_arbiter: a protocol/arithmetic model
// predicts grants and results, a monitor checks every response the DUT offers.
module tb_fixed_point_mult_arbiter;

  localparam int BW = 24;
  localparam int NR = 4;

  typedef struct {
    logic [1:0]    id;
    logic [BW-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    reqValid;
  logic [NR-1:0]    req_ready;
  logic [NR*BW-1:0] aBus;
  logic [NR*BW-1:0] bBus;
  logic             rsp_valid;
  logic             rspReady;
  logic [BW-1:0]    rsp_data;
  logic [1:0]       rsp_id;
  logic             busy;

  int   total = 0;
  int   bad = 0;
  int   cycleCount = 0;
  exp_t expQ[$];
  int   mState = 0;
  int   mPtr = 0;

  fixed_point_mult_arbiter #(
    .BITSIZE(BW),
    .NREQ(NR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(reqValid),
    .req_ready(req_ready),
    .req_a(aBus),
    .req_b(bBus),
    .rsp_valid(rsp_valid),
    .rsp_ready(rspReady),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Q4.19 multiply done with plain integer arithmetic: exact product, floor, clamp.
  function automatic logic [BW-1:0] mulRef(input logic [BW-1:0] a, input logic [BW-1:0] b);
    longint sa;
    longint sb;
    longint p;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = (sa * sb) >>> 19;
    if (p > 64'sd8388607) p = 64'sd8388607;
    if (p < -64'sd8388608) p = -64'sd8388608;
    pv = p;
    return pv[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      2: return 24'h000000;
      3: return 24'hFFFFFF;
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*BW-1:0] a,
                               input logic [NR*BW-1:0] b, input logic rr);
    @(posedge clk);
    #1;
    reqValid = v;
    aBus     = a;
    bBus     = b;
    rspReady = rr;
  endtask

  task automatic waitGrant(input int budget, output logic [NR-1:0] g, output int cyc);
    g = '0;
    cyc = 0;
    for (int i = 0; i < budget && g == '0; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        cyc = cycleCount;
      end
    end
  endtask

  // Reference model: one operation at a time (accept, compute, hold until taken),
  // winner is the first valid requester at or after the round-robin pointer.
  always @(negedge clk) begin
    logic [NR-1:0] expReady;
    int winner;
    if (!rst_n) begin
      mState = 0;
      mPtr = 0;
      expQ.delete();
    end else begin
      winner = -1;
      for (int k = 0; k < NR; k++) begin
        if (winner < 0 && reqValid[(mPtr + k) % NR]) winner = (mPtr + k) % NR;
      end
      expReady = '0;
      if (mState == 0 && winner >= 0) expReady[winner] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      checkOutput("busy", 64'(busy), 64'(mState != 0));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(mState == 2));
      case (mState)
        0: if (winner >= 0) begin
             expQ.push_back('{id: 2'(winner),
                              data: mulRef(aBus[winner*BW +: BW], bBus[winner*BW +: BW])});
             mPtr = (winner + 1) % NR;
             mState = 1;
           end
        1: mState = 2;
        default: if (rspReady) mState = 0;
      endcase
    end
  end

  // Monitor: every offered response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checkOutput("rsp_expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        checkOutput("rsp_data", 64'(rsp_data), 64'(expQ[0].data));
        checkOutput("rsp_id", 64'(rsp_id), 64'(expQ[0].id));
        if (rspReady) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NR*BW-1:0] a;
    logic [NR*BW-1:0] b;
    logic [NR-1:0]    g;
    logic [BW-1:0]    bpExp;
    int               cyc;
    int               prevCyc;

    rst_n = 1'b0;
    reqValid = '0;
    aBus = '0;
    bBus = '0;
    rspReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: 0.5 * 0.5 = 0.25.
    a = '0;
    b = '0;
    a[23:0] = 24'h040000;
    b[23:0] = 24'h040000;
    applyStimulus(4'b0001, a, b, 1'b1);
    @(negedge clk);
    checkOutput("single_grant", 64'(req_ready), 64'h1);
    applyStimulus(4'b0000, a, b, 1'b1);
    @(negedge clk);
    checkOutput("single_valid_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("single_valid", 64'(rsp_valid), 64'd1);
    checkOutput("single_data", 64'(rsp_data), 64'h020000);
    checkOutput("single_id", 64'(rsp_id), 64'd0);

    // Reset while the operation is in MUL.
    a[71:48] = 24'h123456;
    b[71:48] = 24'h0ABCDE;
    applyStimulus(4'b0100, a, b, 1'b1);
    @(negedge clk);
    checkOutput("pre_reset_grant", 64'(req_ready), 64'h4);
    applyStimulus(4'b0000, a, b, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_rst_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("async_rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    end

    // All requesters valid: rotation 0,1,2,3,0 three cycles apart.
    for (int i = 0; i < NR; i++) begin
      a[i*BW +: BW] = randOperand();
      b[i*BW +: BW] = randOperand();
    end
    applyStimulus(4'b1111, a, b, 1'b1);
    prevCyc = 0;
    for (int k = 0; k < 5; k++) begin
      waitGrant(10, g, cyc);
      checkOutput("rotate_grant", 64'(g), 64'(1 << (k % NR)));
      if (k > 0) checkOutput("rotate_spacing", 64'(cyc - prevCyc), 64'd3);
      prevCyc = cyc;
    end
    applyStimulus(4'b0000, a, b, 1'b1);
    repeat (3) @(posedge clk);

    // Backpressure: hold the result for five cycles, then release.
    for (int i = 0; i < NR; i++) begin
      a[i*BW +: BW] = randOperand();
      b[i*BW +: BW] = randOperand();
    end
    bpExp = mulRef(a[47:24], b[47:24]);
    applyStimulus(4'b1111, a, b, 1'b0);
    @(negedge clk);
    checkOutput("bp_grant", 64'(req_ready), 64'h2);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_hold_busy", 64'(busy), 64'd1);
      checkOutput("bp_hold_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_hold_data", 64'(rsp_data), 64'(bpExp));
      checkOutput("bp_hold_id", 64'(rsp_id), 64'd1);
    end
    applyStimulus(4'b1111, a, b, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_valid", 64'(rsp_valid), 64'd1);
    applyStimulus(4'b0000, a, b, 1'b1);
    @(negedge clk);
    checkOutput("bp_done_valid", 64'(rsp_valid), 64'd0);
    checkOutput("bp_done_busy", 64'(busy), 64'd0);

    // Pointer wrap: grant 3, then {3,1} valid gives 1, then pointer sits at 2.
    applyStimulus(4'b1000, a, b, 1'b1);
    @(negedge clk);
    checkOutput("wrap_grant3", 64'(req_ready), 64'h8);
    applyStimulus(4'b0000, a, b, 1'b1);
    applyStimulus(4'b1010, a, b, 1'b1);
    waitGrant(5, g, cyc);
    checkOutput("wrap_grant1", 64'(g), 64'h2);
    applyStimulus(4'b0000, a, b, 1'b1);
    applyStimulus(4'b1111, a, b, 1'b1);
    waitGrant(5, g, cyc);
    checkOutput("wrap_ptr_is_2", 64'(g), 64'h4);
    applyStimulus(4'b0000, a, b, 1'b1);
    repeat (3) @(posedge clk);

    // Random traffic with random backpressure and saturating corner operands.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        a[i*BW +: BW] = randOperand();
        b[i*BW +: BW] = randOperand();
      end
      applyStimulus(NR'($urandom_range(0, 15)), a, b, ($urandom_range(0, 3) != 0));
    end
    applyStimulus(4'b0000, a, b, 1'b1);
    repeat (8) @(posedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_point_mult_arbiter.md
FIXED_POINT_MULT_ARBITER -- requirements
Module: fixed_point_mult_arbiter

Interface
REQ-001 Parameter BITSIZE, default 24, operand/result width (1 sign, 4 integer, 19 fraction bits).
REQ-002 Parameter NREQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 req_ready  output  NREQ  per-requester accept strobe (one-hot or zero).
REQ-007 req_a  input  NREQ*BITSIZE  operand A per requester; slice i = bits [i*BITSIZE +: BITSIZE].
REQ-008 req_b  input  NREQ*BITSIZE  operand B per requester; same slicing.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  BITSIZE  product of the accepted pair.
REQ-012 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_data.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have three states: IDLE, MUL, RESP.
REQ-015 IDLE: if any req_valid bit is set, the arbiter SHALL assert req_ready for exactly one winner, chosen round-robin starting at pointer rr_ptr and searching upward with wrap from NREQ-1 to 0.
REQ-016 req_ready SHALL be combinational from state, rr_ptr and req_valid; all-zero outside IDLE or when no request is valid.
REQ-017 On handshake (req_valid[g] & req_ready[g]): latch req_a/req_b slice g and id g into operand registers; set rr_ptr to (g+1) mod NREQ; go to MUL.
REQ-018 MUL (exactly one cycle): register the multiplier output into rsp_data, drive rsp_id with the latched id, set rsp_valid; go to RESP.
REQ-019 RESP: hold rsp_valid, rsp_data and rsp_id stable until rsp_ready is high; on that cycle clear rsp_valid and go to IDLE.
REQ-020 Latency: rsp_valid SHALL rise 2 cycles after the request handshake edge; throughput at most one operation per 3 cycles.
REQ-021 rr_ptr SHALL not change when no handshake occurs; with all requesters valid, grants SHALL rotate 0,1,...,NREQ-1,0.
REQ-022 Requesters SHALL hold req_valid and operands until ready; deassertion before ready is legal and SHALL cause no grant.
REQ-023 rsp_ready high in RESP's first cycle SHALL complete the transfer that cycle; rsp_ready outside RESP SHALL be ignored.
REQ-024 Product arithmetic, saturation and sign handling SHALL be exactly that of the shared multiplier; this block SHALL not alter the result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rr_ptr 0, rsp_valid 0, rsp_data 0, rsp_id 0, operand registers 0, busy 0.
REQ-026 Reset during MUL or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/MUL/RESP) and the default BITSIZE and NREQ constants.
REQ-028 Exactly one sub-module SHALL be instantiated: the team's combinational fixed_point_multiply with BITSIZE, fed from the operand registers.

Verification
REQ-029 Single request: req_valid=4'b0001, A=24'h040000, B=24'h040000, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_data=24'h020000, rsp_id=0.
REQ-030 All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0, each grant 3 cycles apart.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, req_ready all zero, busy=1, then one-cycle completion on rsp_ready.
REQ-032 Reset asserted in MUL -> outputs zero asynchronously, no response after release, next grant starts at requester 0.
REQ-033 Pointer wrap: only requesters 3 and 1 valid after a grant to 3 -> next grant 1, rr_ptr=2.
REQ-034 Random operands on all ports -> every rsp_data equals a standalone multiplier model for the operands of requester rsp_id.
